// File: rtl/oserdes_tx_sequencer.sv
// OSERDESE2 lane sequencer: reset/OCE bring-up, training burst, then gated
// word stream with idle insertion and a saturating underflow counter.
module oserdes_tx_sequencer #(
  parameter int               DATA_WIDTH    = 8,
  parameter int               RST_CYCLES    = 4,
  parameter int               OCE_CYCLES    = 2,
  parameter int               TRAIN_WORDS   = 16,
  parameter logic [7:0]       TRAIN_PATTERN = 8'hBC,
  parameter logic [7:0]       IDLE_WORD     = 8'h00,
  parameter int               UFLOW_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   retrain,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  serdes_d,
  output logic                   serdes_rst,
  output logic                   serdes_oce,
  output logic                   training,
  output logic                   running,
  output logic [UFLOW_WIDTH-1:0] uflow_count,
  input  logic                   uflow_clear
);

  if (DATA_WIDTH < 4 || DATA_WIDTH > 8) begin : g_bad_data_width
    $error("oserdes_tx_sequencer: DATA_WIDTH must be 4..8");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("oserdes_tx_sequencer: RST_CYCLES must be >= 1");
  end
  if (OCE_CYCLES < 1) begin : g_bad_oce_cycles
    $error("oserdes_tx_sequencer: OCE_CYCLES must be >= 1");
  end
  if (TRAIN_WORDS < 0) begin : g_bad_train_words
    $error("oserdes_tx_sequencer: TRAIN_WORDS must be >= 0");
  end
  if (UFLOW_WIDTH < 1) begin : g_bad_uflow_width
    $error("oserdes_tx_sequencer: UFLOW_WIDTH must be >= 1");
  end

  localparam int CNT_MAX_A = (RST_CYCLES > OCE_CYCLES) ? RST_CYCLES : OCE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TRAIN_WORDS) ? CNT_MAX_A : TRAIN_WORDS;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // cnt holds the number of edges already spent in the current phase
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] OCE_LAST   = CNT_W'(OCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRAIN_LAST = (TRAIN_WORDS > 0) ? CNT_W'(TRAIN_WORDS - 1) : '0;

  localparam logic [DATA_WIDTH-1:0] TRAIN_D = TRAIN_PATTERN[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] IDLE_D  = IDLE_WORD[DATA_WIDTH-1:0];

  typedef enum logic [1:0] {HOLD, WARM, TRAIN, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]  d_next;
  logic                   srst_next, oce_next, training_next, running_next;
  logic [UFLOW_WIDTH-1:0] uflow_next;

  assign s_ready = running & ~retrain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= HOLD;
      cnt_reg     <= '0;
      serdes_rst  <= 1'b1;
      serdes_oce  <= 1'b0;
      serdes_d    <= IDLE_D;
      training    <= 1'b0;
      running     <= 1'b0;
      uflow_count <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      serdes_rst  <= srst_next;
      serdes_oce  <= oce_next;
      serdes_d    <= d_next;
      training    <= training_next;
      running     <= running_next;
      uflow_count <= uflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    srst_next     = serdes_rst;
    oce_next      = serdes_oce;
    d_next        = serdes_d;
    training_next = training;
    running_next  = running;
    uflow_next    = uflow_count;

    if (retrain) begin
      state_next    = HOLD;
      cnt_next      = '0;
      srst_next     = 1'b1;
      oce_next      = 1'b0;
      training_next = 1'b0;
      running_next  = 1'b0;
      d_next        = IDLE_D;
    end else begin
      case (state_reg)
        HOLD: begin
          d_next = IDLE_D;
          if (cnt_reg == RST_LAST) begin
            state_next = WARM;
            cnt_next   = '0;
            srst_next  = 1'b0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        WARM: begin
          d_next = IDLE_D;
          if (cnt_reg == OCE_LAST) begin
            oce_next = 1'b1;
            cnt_next = '0;
            if (TRAIN_WORDS > 0) begin
              state_next    = TRAIN;
              training_next = 1'b1;
              d_next        = TRAIN_D;
            end else begin
              state_next   = RUN;
              running_next = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        TRAIN: begin
          d_next = TRAIN_D;
          if (cnt_reg == TRAIN_LAST) begin
            state_next    = RUN;
            cnt_next      = '0;
            training_next = 1'b0;
            running_next  = 1'b1;
            d_next        = IDLE_D;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          if (s_valid && s_ready) begin
            d_next = s_data;
          end else begin
            d_next = IDLE_D;
            if (uflow_count != '1) uflow_next = uflow_count + 1'b1;
          end
        end
      endcase
    end

    // clear wins over a same-cycle increment
    if (uflow_clear) uflow_next = '0;
  end

endmodule
